// File: rtl/cla_nibble_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : cla_nibble_serial_seq
// Description : Runs a W-bit add/subtract (W = 4*NIBBLES) through a single
//               external combinational 4-bit CLA slice, one nibble per clock.
//               The carry out of each nibble is registered and fed back as the
//               carry-in of the next nibble.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               start, sub, a, b    - request handshake and operands
//               busy, done          - busy in RUN/DONE, one-cycle done pulse
//               sum, cout, ovf      - result, MSB carry, signed overflow
//               cla_a, cla_b, cla_cin, cla_s, cla_cout - external CLA link
// Revision    : 1.0 - initial release
// ============================================================================
module cla_nibble_serial_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic [3:0]             cla_a,
    output logic [3:0]             cla_b,
    output logic                   cla_cin,
    input  logic [3:0]             cla_s,
    input  logic                   cla_cout
);

    localparam int W     = 4 * NIBBLES;
    // idx must be able to hold NIBBLES (value after the final nibble edge)
    localparam int IDX_W = $clog2(NIBBLES + 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;     // holds B' (already inverted for sub)
    logic [W-1:0]     sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    // Bit offset of the current nibble, and the operands shifted down so that
    // the active nibble sits in bits [3:0]. Shifting avoids out-of-range
    // part-selects when idx has already advanced past the last nibble.
    logic [IDX_W+1:0] w_sh;
    logic [W-1:0]     w_a_shift;
    logic [W-1:0]     w_b_shift;

    assign w_sh      = {idx_q, 2'b00};
    assign w_a_shift = a_q >> w_sh;
    assign w_b_shift = b_q >> w_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cla_a   = 4'h0;
        cla_b   = 4'h0;
        cla_cin = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    // Subtraction is A + ~B + 1: the +1 enters as initial carry
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                cla_a   = w_a_shift[3:0];
                cla_b   = w_b_shift[3:0];
                cla_cin = carry_q;
                // Overwrite only the active nibble of sum
                sum_d   = (sum_q & ~(W'(4'hF) << w_sh)) | (W'(cla_s) << w_sh);
                carry_d = cla_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == C_LAST_IDX) begin
                    cout_d  = cla_cout;
                    // Overflow: operand signs agree but result sign differs
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (cla_s[3] != a_q[W-1]);
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_nibble_serial_seq
// Description : Self-checking bench for cla_nibble_serial_seq (NIBBLES=4).
//               Provides a behavioural 4-bit CLA and compares results with a
//               whole-word integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_nibble_serial_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sub = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, cout, ovf, cla_cin, cla_cout;
    logic [W-1:0]  sum;
    logic [3:0]    cla_a, cla_b, cla_s;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural combinational CLA slice
    assign {cla_cout, cla_s} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};

    cla_nibble_serial_seq #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .cla_a    (cla_a),
        .cla_b    (cla_b),
        .cla_cin  (cla_cin),
        .cla_s    (cla_s),
        .cla_cout (cla_cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference using plain integer arithmetic
    task automatic ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rs,
                          output logic [W-1:0] rsum, output logic rcout, output logic rovf);
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'(ra);
        ub = longint'(rb);
        sa = ra[W-1] ? ua - (longint'(1) << W) : ua;
        sb = rb[W-1] ? ub - (longint'(1) << W) : ub;
        if (rs) begin
            ur    = ua - ub;
            rcout = (ua >= ub);
            sr    = sa - sb;
        end else begin
            ur    = ua + ub;
            rcout = (ur >= (longint'(1) << W));
            sr    = sa + sb;
        end
        rsum = W'(ur);
        rovf = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
    endtask

    // One full operation with latency, busy and result checks
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                         input string tag);
        logic [W-1:0] esum;
        logic         ecout, eovf;
        int           lat;
        ref_op(oa, ob, os, esum, ecout, eovf);
        @(negedge clk);
        a = oa; b = ob; sub = os; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~oa; b = ~ob; sub = ~os;   // operands must already be latched
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_cin0"}, 64'(cla_cin), 64'(os));
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(NIBBLES));
        chk({tag, "_sum"},  64'(sum),  64'(esum));
        chk({tag, "_cout"}, 64'(cout), 64'(ecout));
        chk({tag, "_ovf"},  64'(ovf),  64'(eovf));
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, 64'({busy, done}), 64'd0);
        chk({tag, "_hold"}, 64'(sum), 64'(esum));
    endtask

    initial begin : main
        logic [W-1:0]     esum, ra, rb;
        logic             ecout, eovf, rs, m_idle, exp_done;
        int               m_cnt;
        logic [W+1:0]     q[$];
        logic [W+1:0]     item;

        // Reset state
        #12;
        chk("reset_outs", 64'({busy, done, cout, ovf, cla_cin}), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cla", 64'({cla_a, cla_b}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_cla", 64'({cla_a, cla_b, cla_cin, busy}), 64'd0);

        // Directed cases
        do_op(16'h1234, 16'h0FFF, 1'b0, "add_1234_0fff");
        do_op(16'hFFFF, 16'h0001, 1'b0, "add_ffff_0001");
        do_op(16'h0005, 16'h0007, 1'b1, "sub_0005_0007");
        do_op(16'h8000, 16'h0001, 1'b1, "sub_8000_0001");
        do_op(16'h7FFF, 16'h0001, 1'b0, "add_7fff_0001");
        do_op(16'h0000, 16'h0000, 1'b1, "sub_0_0");
        ref_op(16'h1234, 16'h0FFF, 1'b0, esum, ecout, eovf);
        chk("model_sanity_sum", 64'(esum), 64'h2233);

        // Random operations
        for (int i = 0; i < 16; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), "rand_op");
        end

        // start held every cycle with changing operands
        m_idle = 1'b1;
        m_cnt  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            a = ra; b = rb; sub = rs; start = 1'b1;
            @(posedge clk);
            if (m_idle) begin
                ref_op(ra, rb, rs, esum, ecout, eovf);
                q.push_back({esum, ecout, eovf});
                m_idle = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
                if (m_cnt == NIBBLES + 1) m_idle = 1'b1;
            end
            #1;
            exp_done = !m_idle && (m_cnt == NIBBLES);
            chk("stream_done", 64'(done), 64'(exp_done));
            if (done && exp_done && q.size() > 0) begin
                item = q.pop_front();
                chk("stream_result", 64'({sum, cout, ovf}), 64'(item));
            end
        end
        @(negedge clk);
        start = 1'b0;
        // drain any in-flight op
        for (int cyc = 0; cyc < NIBBLES + 2; cyc++) begin
            @(posedge clk);
            #1;
            if (done && q.size() > 0) begin
                item = q.pop_front();
                chk("stream_tail", 64'({sum, cout, ovf}), 64'(item));
            end
        end
        chk("stream_queue_empty", 64'(q.size()), 64'd0);

        // Reset during RUN cycle 2
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", 64'({busy, done, cout, ovf, cla_cin}), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cla", 64'({cla_a, cla_b}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_done = 1'b0;
        for (int cyc = 0; cyc < NIBBLES + 3; cyc++) begin
            @(posedge clk);
            #1;
            exp_done = exp_done | done | busy;
        end
        chk("no_done_after_abort", 64'(exp_done), 64'd0);
        do_op(16'h4321, 16'h1234, 1'b1, "post_reset_sub");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
